// File: rtl/syst_feeder_pkg.sv
// Shared types and helpers for the systolic-array input feeder.
package syst_feeder_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    // Bit offset of lane r inside a packed word of w-bit lanes.
    function automatic int unsigned lane_lsb(input int unsigned r, input int unsigned w);
        return r * w;
    endfunction

endpackage

// File: rtl/syst_skew_lane.sv
// One lane of the de-skew pipeline: DEPTH enabled delay stages plus an output register.
module syst_skew_lane #(
    parameter int unsigned DEPTH   = 0,
    parameter int unsigned X_WIDTH = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               en_i,
    input  logic [X_WIDTH-1:0] data_i,
    input  logic               valid_i,
    output logic [X_WIDTH-1:0] data_o,
    output logic               valid_o
);

    logic [X_WIDTH-1:0] tail_data;
    logic               tail_valid;
    logic [X_WIDTH-1:0] out_data_q;
    logic               out_valid_q;

    if (DEPTH > 0) begin : g_dly
        logic [X_WIDTH-1:0] dat_q [DEPTH];
        logic [DEPTH-1:0]   vld_q;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int unsigned i = 0; i < DEPTH; i++) dat_q[i] <= '0;
                vld_q <= '0;
            end else if (en_i) begin
                dat_q[0] <= data_i;
                vld_q[0] <= valid_i;
                for (int unsigned i = 1; i < DEPTH; i++) begin
                    dat_q[i] <= dat_q[i-1];
                    vld_q[i] <= vld_q[i-1];
                end
            end
        end

        assign tail_data  = dat_q[DEPTH-1];
        assign tail_valid = vld_q[DEPTH-1];
    end else begin : g_nodly
        assign tail_data  = data_i;
        assign tail_valid = valid_i;
    end

    // Valid drops on bubbles but data holds, so the array sees an aligned stall.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else if (en_i) begin
            out_data_q  <= tail_valid ? tail_data : '0;
            out_valid_q <= tail_valid;
        end else begin
            out_valid_q <= 1'b0;
        end
    end

    assign data_o  = out_data_q;
    assign valid_o = out_valid_q;

endmodule

// File: rtl/syst_feeder.sv
// Streams a tile of words into the systolic array as a diagonal wavefront, then drains the skew.
module syst_feeder
    import syst_feeder_pkg::*;
#(
    parameter int WORD     = 32,
    parameter int X_WIDTH  = 8,
    parameter int col      = 4,
    parameter int TILE_LEN = 16,
    parameter int CNT_W    = 5
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic [WORD-1:0] s_data_i,
    input  logic            s_valid_i,
    output logic            s_ready_o,
    output logic [WORD-1:0] data_o,
    output logic            valid_o,
    output logic [col-1:0]  valid_raw_o,
    output logic            busy_o,
    output logic            done_o
);

    localparam logic [CNT_W-1:0] LAST_WORD  = CNT_W'(TILE_LEN - 1);
    localparam logic [CNT_W-1:0] LAST_DRAIN = CNT_W'((col > 1) ? col - 2 : 0);

    state_t           state_q;
    logic [CNT_W-1:0] wcnt_q;
    logic [CNT_W-1:0] dcnt_q;
    logic             done_q;
    logic             accept;
    logic             advance;

    assign s_ready_o = (state_q == STREAM);
    assign accept    = s_valid_i & s_ready_o;
    assign advance   = accept | (state_q == DRAIN);
    assign busy_o    = (state_q != IDLE);
    assign done_o    = done_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
            dcnt_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q <= STREAM;
                        wcnt_q  <= '0;
                    end
                end
                STREAM: begin
                    if (accept) begin
                        if (wcnt_q == LAST_WORD) begin
                            wcnt_q <= '0;
                            dcnt_q <= '0;
                            // A single lane has no skew to drain.
                            if (col == 1) begin
                                state_q <= IDLE;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= DRAIN;
                            end
                        end else begin
                            wcnt_q <= wcnt_q + CNT_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (dcnt_q == LAST_DRAIN) begin
                        state_q <= IDLE;
                        dcnt_q  <= '0;
                        done_q  <= 1'b1;
                    end else begin
                        dcnt_q <= dcnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    for (genvar r = 0; r < col; r++) begin : g_lane
        localparam int unsigned LSB = lane_lsb(r, X_WIDTH);
        logic [X_WIDTH-1:0] lane_in;

        assign lane_in = accept ? s_data_i[LSB +: X_WIDTH] : '0;

        syst_skew_lane #(
            .DEPTH   (r),
            .X_WIDTH (X_WIDTH)
        ) u_lane (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .en_i    (advance),
            .data_i  (lane_in),
            .valid_i (accept),
            .data_o  (data_o[LSB +: X_WIDTH]),
            .valid_o (valid_raw_o[r])
        );
    end

    assign valid_o = |valid_raw_o;

endmodule
